execute_hazard_controller: RTL and testbench
============================================

Name: execute_hazard_controller

Overview:
- Sequences the execute stage: holds the pipeline while the multi-cycle vector ALU completes, and inserts a one-cycle bubble on load-use hazards.
- Sits beside the forwarding unit.
- Drives the stall enables of the fetch and decode registers, the hold enable of the DecodeExecute register, the nop-mux select, and a bubble select into the ExecuteMemory register.

Parameters:
VEC_LATENCY, 4, total execute-stage cycles a vector ALU operation occupies; legal range 1..16
REG_ADDR_WIDTH, 5, register-index width

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
rs1_decode  input  REG_ADDR_WIDTH  source 1 index of the instruction in decode
rs2_decode  input  REG_ADDR_WIDTH  source 2 index of the instruction in decode
rd_execute  input  REG_ADDR_WIDTH  destination index of the instruction in execute
wre_execute  input  1  the instruction in execute writes the register file
load_instruction  input  1  the instruction in execute is a load
vector_op_execute  input  1  the instruction in execute uses the vector ALU
stall_fetch  output  1  hold the PC / fetch register
stall_decode  output  1  hold the FetchDecode register
stall_execute  output  1  hold the DecodeExecute register
nop_select_decode  output  1  nop mux selects zero control word (bubble into execute)
bubble_memory  output  1  ExecuteMemory register captures nop control (wre and memory write enables 0)
vector_busy  output  1  FSM in VEC_RUN
vector_remaining  output  4  stall cycles left in current vector op
stall_count  output  16  saturating count of stall cycles since reset

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high: reset=1 at a rising edge of clk resets the block.
- States: IDLE, LOAD_STALL, VEC_RUN. vector_remaining counter: 4 bits.
- Stall outputs are combinational from state and inputs (Mealy). State, counter and stall_count are registered.
- Reset:
  - Next state is IDLE, vector_remaining=0, stall_count=0.
  - While reset=1, all stall/bubble/select outputs are forced 0, including mid-operation; the abandoned vector op is not resumed.
- Load-use hazard, in IDLE: hazard = load_instruction & wre_execute & rd_execute!=0 & (rd_execute==rs1_decode | rd_execute==rs2_decode).
  - On hazard: stall_fetch=stall_decode=nop_select_decode=1; stall_execute=0, bubble_memory=0.
  - Next state LOAD_STALL.
  - The load advances to memory normally, and a bubble enters execute.
- LOAD_STALL:
  - All outputs 0.
  - Next state IDLE.
  - No new hazard is evaluated, because execute holds the bubble.
  - Exactly one stall cycle per load-use hazard.
- Vector op in IDLE, vector_op_execute=1 (priority over load-use if both asserted; that combination is illegal):
  - VEC_LATENCY==1: no action, all outputs 0.
  - Otherwise: stall_fetch=stall_decode=stall_execute=bubble_memory=1; vector_remaining<=VEC_LATENCY-2; next state VEC_RUN.
- VEC_RUN, vector_busy=1:
  - vector_remaining>0: same four stalls asserted, vector_remaining decrements.
  - vector_remaining==0: all stalls 0; the op advances into ExecuteMemory at the edge; next state IDLE.
  - Total stall cycles per vector op = VEC_LATENCY-1. The op is in execute for VEC_LATENCY cycles, and the ALU result is valid in the last one.
- vector_op_execute remaining high during VEC_RUN does not restart the sequence; only the state decides.
- Back-to-back vector ops: the second op enters execute on the cycle after VEC_RUN exits. It is seen in IDLE and starts a new sequence.
- stall_count:
  - Increments on every cycle where stall_fetch=1 and reset=0.
  - Saturates at 16'hFFFF.
- rd_execute==0 never causes a load-use hazard.

Test Plan:
- Reset held 2 cycles with vector_op_execute=1 → all outputs 0, vector_busy=0, stall_count=0 after release.
- Load-use hazard → exactly one stall cycle, then no stall; stall_count=1.
  - Stimulus: load_instruction=1, wre_execute=1, rd_execute=3, rs1_decode=3.
  - That cycle: stall_fetch=stall_decode=nop_select_decode=1, stall_execute=0.
- Load, no hazard → no stall. Covers both cases:
  - rd_execute=0, rs1_decode=0.
  - rd_execute=3, rs1_decode=1, rs2_decode=2.
- Vector op, VEC_LATENCY=4, vector_op_execute held 4 cycles → stall_execute=bubble_memory=1 for 3 cycles, vector_remaining 2,1,0, then 0 in the 4th cycle; stall_count=3.
- Two back-to-back vector ops → 3 stall cycles, 1 free cycle, 3 stall cycles; stall_count=6.
- Vector op with reset asserted on its 2nd cycle → outputs 0 on that cycle, state IDLE afterward, stall_count=0.
- VEC_LATENCY=1 build with vector_op_execute=1 → no stall ever.

Source files
------------

// File: rtl/execute_hazard_controller.sv
// Execute-stage hazard sequencer: one-cycle bubble on load-use hazards and a
// multi-cycle pipeline hold while the vector ALU completes.
module execute_hazard_controller #(
    parameter int VEC_LATENCY    = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_decode,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_decode,
    input  logic [REG_ADDR_WIDTH-1:0] rd_execute,
    input  logic                      wre_execute,
    input  logic                      load_instruction,
    input  logic                      vector_op_execute,
    output logic                      stall_fetch,
    output logic                      stall_decode,
    output logic                      stall_execute,
    output logic                      nop_select_decode,
    output logic                      bubble_memory,
    output logic                      vector_busy,
    output logic [3:0]                vector_remaining,
    output logic [15:0]               stall_count
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_STALL = 2'd1,
        VEC_RUN    = 2'd2
    } state_t;

    // The first stall cycle happens in IDLE, so VEC_RUN starts at latency-2.
    localparam int         VEC_START_I = (VEC_LATENCY > 1) ? VEC_LATENCY - 2 : 0;
    localparam logic [3:0] VEC_START   = VEC_START_I[3:0];

    state_t      state_q, state_d;
    logic [3:0]  vec_rem_q, vec_rem_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic hazard;
    logic vec_stall;
    logic load_bubble;

    assign hazard = load_instruction && wre_execute && (rd_execute != '0) &&
                    ((rd_execute == rs1_decode) || (rd_execute == rs2_decode));

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        vec_rem_d   = vec_rem_q;
        vec_stall   = 1'b0;
        load_bubble = 1'b0;

        case (state_q)
            IDLE: begin
                if (vector_op_execute) begin
                    if (VEC_LATENCY > 1) begin
                        vec_stall = 1'b1;
                        vec_rem_d = VEC_START;
                        state_d   = VEC_RUN;
                    end
                end else if (hazard) begin
                    load_bubble = 1'b1;
                    state_d     = LOAD_STALL;
                end
            end
            LOAD_STALL: state_d = IDLE;
            VEC_RUN: begin
                if (vec_rem_q != 4'd0) begin
                    vec_stall = 1'b1;
                    vec_rem_d = vec_rem_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset suppresses every pipeline control, even mid-operation.
        if (reset) begin
            vec_stall   = 1'b0;
            load_bubble = 1'b0;
        end

        stall_fetch       = vec_stall || load_bubble;
        stall_decode      = vec_stall || load_bubble;
        stall_execute     = vec_stall;
        bubble_memory     = vec_stall;
        nop_select_decode = load_bubble;

        stall_cnt_d = stall_cnt_q;
        if (stall_fetch && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state_q     <= IDLE;
            vec_rem_q   <= 4'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            vec_rem_q   <= vec_rem_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign vector_busy      = (state_q == VEC_RUN);
    assign vector_remaining = vec_rem_q;
    assign stall_count      = stall_cnt_q;

endmodule

// File: tb/tb_execute_hazard_controller.sv
// Randomized bench for execute_hazard_controller: latency-4 and latency-1
// instances share stimulus and are checked against a cycle-level model.
module tb_execute_hazard_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1_decode, rs2_decode, rd_execute;
    logic       wre_execute, load_instruction, vector_op_execute;

    logic        a_sf, a_sd, a_se, a_nop, a_bub, a_busy;
    logic [3:0]  a_rem;
    logic [15:0] a_cnt;
    logic        b_sf, b_sd, b_se, b_nop, b_bub, b_busy;
    logic [3:0]  b_rem;
    logic [15:0] b_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    execute_hazard_controller #(.VEC_LATENCY(4), .REG_ADDR_WIDTH(5)) dut_a (
        .clk(clk), .reset(reset),
        .rs1_decode(rs1_decode), .rs2_decode(rs2_decode), .rd_execute(rd_execute),
        .wre_execute(wre_execute), .load_instruction(load_instruction),
        .vector_op_execute(vector_op_execute),
        .stall_fetch(a_sf), .stall_decode(a_sd), .stall_execute(a_se),
        .nop_select_decode(a_nop), .bubble_memory(a_bub), .vector_busy(a_busy),
        .vector_remaining(a_rem), .stall_count(a_cnt)
    );

    execute_hazard_controller #(.VEC_LATENCY(1), .REG_ADDR_WIDTH(5)) dut_b (
        .clk(clk), .reset(reset),
        .rs1_decode(rs1_decode), .rs2_decode(rs2_decode), .rd_execute(rd_execute),
        .wre_execute(wre_execute), .load_instruction(load_instruction),
        .vector_op_execute(vector_op_execute),
        .stall_fetch(b_sf), .stall_decode(b_sd), .stall_execute(b_se),
        .nop_select_decode(b_nop), .bubble_memory(b_bub), .vector_busy(b_busy),
        .vector_remaining(b_rem), .stall_count(b_cnt)
    );

    // Model: phase 0 = free, 1 = load bubble in execute, 2 = vector op running.
    // vec_left counts the cycles the op still spends in execute after the first.
    typedef struct {
        int phase;
        int vec_left;
        int cnt;
    } model_t;

    model_t ma, mb;

    function automatic logic is_hazard();
        return load_instruction && wre_execute && (rd_execute != 0) &&
               ((rd_execute == rs1_decode) || (rd_execute == rs2_decode));
    endfunction

    // Packed as {fetch, decode, execute, nop, bubble, busy, remaining[3:0], count[15:0]}.
    function automatic logic [25:0] expected(input model_t m, input int lat);
        logic f, d, e, n, b, busy;
        int   rem;
        f = 0; d = 0; e = 0; n = 0; b = 0;
        if (!reset) begin
            if (m.phase == 0) begin
                if (vector_op_execute) begin
                    if (lat > 1) begin f = 1; d = 1; e = 1; b = 1; end
                end else if (is_hazard()) begin
                    f = 1; d = 1; n = 1;
                end
            end else if (m.phase == 2 && m.vec_left > 1) begin
                f = 1; d = 1; e = 1; b = 1;
            end
        end
        busy = (m.phase == 2);
        rem  = busy ? m.vec_left - 1 : 0;
        return {f, d, e, n, b, busy, rem[3:0], m.cnt[15:0]};
    endfunction

    function automatic model_t step(input model_t m, input int lat, input logic stalled);
        model_t r;
        r = m;
        if (reset) begin
            r.phase = 0; r.vec_left = 0; r.cnt = 0;
            return r;
        end
        if (stalled && r.cnt < 65535) r.cnt++;
        case (m.phase)
            0: begin
                if (vector_op_execute) begin
                    if (lat > 1) begin r.phase = 2; r.vec_left = lat - 1; end
                end else if (is_hazard()) begin
                    r.phase = 1;
                end
            end
            1: r.phase = 0;
            default: begin
                r.vec_left = m.vec_left - 1;
                if (r.vec_left == 0) r.phase = 0;
            end
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    // Drive one cycle, compare both instances mid-cycle, then advance the models.
    task automatic run_cycle(input logic r, input logic v, input logic ld, input logic w,
                             input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2);
        logic [25:0] ea, eb;
        reset = r; vector_op_execute = v; load_instruction = ld; wre_execute = w;
        rd_execute = rd; rs1_decode = s1; rs2_decode = s2;
        @(negedge clk);
        ea = expected(ma, 4);
        eb = expected(mb, 1);
        check("lat4_outputs", {6'b0, a_sf, a_sd, a_se, a_nop, a_bub, a_busy, a_rem, a_cnt}, {6'b0, ea});
        check("lat1_outputs", {6'b0, b_sf, b_sd, b_se, b_nop, b_bub, b_busy, b_rem, b_cnt}, {6'b0, eb});
        ma = step(ma, 4, ea[25]);
        mb = step(mb, 1, eb[25]);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_cycle();
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic reset_cycle();
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        logic       v, ld, r;
        logic [4:0] rd, s1, s2;

        // First edge brings both instances out of the unknown state.
        reset = 1'b1; vector_op_execute = 1'b1; load_instruction = 1'b0; wre_execute = 1'b0;
        rd_execute = '0; rs1_decode = '0; rs2_decode = '0;
        ma = '{phase: 0, vec_left: 0, cnt: 0};
        mb = '{phase: 0, vec_left: 0, cnt: 0};
        @(posedge clk);
        #1;
        run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        check("reset_busy", {31'b0, a_busy}, 32'd0);
        check("reset_count", {16'b0, a_cnt}, 32'd0);

        // Load-use hazard: one stall cycle then free.
        run_cycle(1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 5'd0);
        idle_cycle();
        check("load_use_count", {16'b0, a_cnt}, 32'd1);

        // Loads without a hazard.
        run_cycle(1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
        run_cycle(1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 5'd1, 5'd2);
        check("no_hazard_count", {16'b0, a_cnt}, 32'd1);

        // Single vector op held for its full latency.
        reset_cycle();
        for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        check("vec_single_count", {16'b0, a_cnt}, 32'd3);
        check("vec_single_busy", {31'b0, a_busy}, 32'd0);

        // Back-to-back vector ops.
        reset_cycle();
        for (int i = 0; i < 8; i++) run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        check("vec_b2b_count", {16'b0, a_cnt}, 32'd6);

        // Reset lands on the second cycle of a vector op.
        reset_cycle();
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        idle_cycle();
        check("vec_reset_count", {16'b0, a_cnt}, 32'd0);
        check("vec_reset_busy", {31'b0, a_busy}, 32'd0);
        check("lat1_count", {16'b0, b_cnt}, 32'd0);

        // Random traffic; small register range makes hazards frequent.
        for (int i = 0; i < 800; i++) begin
            r  = ($urandom_range(0, 49) == 0);
            v  = ($urandom_range(0, 4) == 0);
            ld = !v && ($urandom_range(0, 2) == 0);
            rd = 5'($urandom_range(0, 3));
            s1 = 5'($urandom_range(0, 3));
            s2 = 5'($urandom_range(0, 3));
            run_cycle(r, v, ld, 1'($urandom_range(0, 1)), rd, s1, s2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
